// File: rtl/lsr_pkg.sv
// Shared definitions for the LSR issue queue: default widths and the request payload.
package lsr_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned SHW_DEFAULT   = 4;
  localparam int unsigned DEPTH_DEFAULT = 4;

  // Request payload at default widths: operand plus shift amount
  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] data;
    logic [SHW_DEFAULT-1:0]   shamt;
  } lsr_req_t;

endpackage

// File: rtl/lsr_issue_queue_if.sv
// Handshake bundle for lsr_issue_queue.
//   in_valid/in_ready/in_data/in_shamt : request side (upstream issue logic)
//   out_valid/out_ready/out_result/out_shamt : result side (writeback consumer)
//   level : FIFO occupancy, excluding the output register
interface lsr_issue_queue_if
  import lsr_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned SHW   = SHW_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
);

  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [SHW-1:0]   out_shamt;
  logic [LW-1:0]    level;

  // Request source and result sink
  modport master (
    output in_valid, in_data, in_shamt, out_ready,
    input  in_ready, out_valid, out_result, out_shamt, level
  );

  // The queue itself
  modport slave (
    input  in_valid, in_data, in_shamt, out_ready,
    output in_ready, out_valid, out_result, out_shamt, level
  );

endinterface

// File: rtl/lsr_issue_queue_lsr.sv
// Combinational logical-shift-right unit.
//   in1    : operand
//   N      : shift amount
//   Result : in1 >> N, zero-filled
module lsr_issue_queue_lsr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 4
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [SHW-1:0]   N,
  output logic [WIDTH-1:0] Result
);

  assign Result = in1 >> N;

endmodule

// File: rtl/lsr_issue_queue.sv
// Operand FIFO in front of the LSR unit with a registered result stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/result handshakes and occupancy (lsr_issue_queue_if.slave)
// in_ready is combinational from occupancy; every other output is registered.
module lsr_issue_queue
  import lsr_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned SHW   = SHW_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  lsr_issue_queue_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shamt;
  } req_t;

  req_t             mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic [SHW-1:0]   out_shamt_q;

  logic             in_ready_c;
  logic             push_c;
  logic             load_c;
  req_t             head_c;
  logic [WIDTH-1:0] shifted_c;

  // Full queue refuses input even if the output stage is draining this cycle
  assign in_ready_c = (level_q != LW'(DEPTH));
  assign push_c     = bus.in_valid && in_ready_c;
  assign load_c     = (level_q != '0) && (!out_valid_q || bus.out_ready);
  assign head_c     = mem[rd_ptr];

  lsr_issue_queue_lsr #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_lsr (head_c.data, head_c.shamt, shifted_c);

  // Storage is not reset; level gates every read
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= {bus.in_data, bus.in_shamt};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (load_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_c, load_c})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Result stage: load from head, hold on stall, drop valid once consumed with nothing queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_shamt_q  <= '0;
    end else if (load_c) begin
      out_valid_q  <= 1'b1;
      out_result_q <= shifted_c;
      out_shamt_q  <= head_c.shamt;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_shamt  = out_shamt_q;
  assign bus.level      = level_q;

endmodule

// File: doc/lsr_issue_queue.md
# lsr_issue_queue

Operand queue and result register around the combinational logical-shift-right (LSR) ALU unit. It accepts shift requests (operand plus shift amount) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It drives the head entry into an internal LSR instance and captures each result in a registered output stage with its own valid/ready handshake. It sits between the ALU operand-issue logic (upstream) and the writeback/result consumer (downstream), and it gives the shifter one-per-cycle throughput under backpressure.

## Interface
- WIDTH, 32, operand and result width
- SHW, 4, shift-amount width; shift range is 0..2^SHW-1
- DEPTH, 4, FIFO entries; must be a power of two and ≥2
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, asynchronous assert, active-low
- in_valid  input  1  request present
- in_ready  output  1  queue can accept (combinational from occupancy)
- in_data  input  WIDTH  operand to shift
- in_shamt  input  SHW  shift amount
- out_valid  output  1  out_result holds an unconsumed result
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  in_data >> in_shamt, zero-filled
- out_shamt  output  SHW  shift amount of the request that produced out_result
- level  output  $clog2(DEPTH+1)  FIFO occupancy (excludes the output register)

## Operation
- Push: fires when in_valid && in_ready. Writes {in_data, in_shamt} at wr_ptr, then increments wr_ptr.
- in_ready = (level != DEPTH). It does not depend on a same-cycle pop, so a full queue refuses input even while draining.
- A push attempted while in_ready=0 is ignored. Storage, pointers and level are unchanged.
- Output load condition: load = (level != 0) && (!out_valid || out_ready).
- On load:
  - out_result <= LSR(head.data, head.shamt).
  - out_shamt <= head.shamt.
  - out_valid <= 1.
  - rd_ptr increments.
- If out_valid && out_ready && level == 0: out_valid <= 0. out_result and out_shamt hold their last values.
- If out_valid && !out_ready: out_result, out_shamt and out_valid hold stable. There is no pop.
- Simultaneous push and load in one cycle: level unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. level disambiguates full from empty.
- Arithmetic is a logical shift with zero fill; shamt=0 passes the data through unchanged.
- Reset (asynchronous, any time, including mid-stream):
  - rd_ptr = wr_ptr = 0, level = 0.
  - out_valid = 0, out_result = 0, out_shamt = 0.
  - Queued entries are discarded.
  - in_ready = 1 during and after reset.
  - FIFO storage needs no reset.

## Timing
- Latency: a request accepted at edge N appears in the FIFO after N. It is loaded into the output register at edge N+1, so out_valid=1 in the cycle after N+1. The minimum accept-to-valid latency is 2 cycles.
- Throughput: 1 request per cycle in steady state when out_ready=1.
- Capacity under full backpressure: DEPTH+1 requests (DEPTH in the FIFO plus 1 in the output register).
- Ordering: strict FIFO; results leave in acceptance order.
- Single clock domain; all outputs except in_ready are registered.

## Structure
- Shared package lsr_pkg holds:
  - WIDTH_DEFAULT=32 and SHW_DEFAULT=4.
  - Typedef lsr_req_t = {data[WIDTH-1:0], shamt[SHW-1:0]}.
- Sub-module: the existing LSR unit, instantiated as u_lsr, positional (in1, N, Result). Its input is the FIFO head.
- FIFO storage and pointers stay inline; no separate FIFO module.

## Test plan
- Single request in_data=2, in_shamt=3, out_ready=1 -> out_valid rises 2 cycles after accept, out_result=0, out_shamt=3.
- Back-to-back stream (1,3),(6,2),(5,9),(10,10),(10,6),(0x80000000,15) with out_ready=1 -> results 0,1,0,0,0,0x00010000 in order, one per cycle.
- Backpressure: out_ready=0 while pushing 6 requests -> 5 accepted, level=4 and in_ready=0 after the 5th; the 6th is held by the source. out_result stays equal to the first result. Releasing out_ready drains all 5 in order.
- Simultaneous push/pop at level=2 -> level stays 2 and results remain ordered. Pointer wrap is exercised by pushing more than 2×DEPTH requests.
- Stall hold: out_ready toggles 0/1 every cycle -> out_result and out_shamt are stable on each stall cycle; no duplicate or dropped results.
- Reset mid-operation: assert rst_n=0 with level=3 and out_valid=1 -> out_valid=0, out_result=0 and level=0 immediately (asynchronous). After release, a new request (0xFFFFFFFF, 4) yields 0x0FFFFFFF.
